// File: rtl/posit_to_float.sv
// posit_to_float: two-stage posit(n,es) to binary64 converter with valid/ready handshakes
module posit_to_float #(
   parameter int n        = 16,
   parameter int es       = 1,
   parameter int FP_WIDTH = 64
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [n-1:0]        operand_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [FP_WIDTH-1:0] result_o
);
   if (n < 3 || n > 32 || es < 0 || es > 3) begin : g_param_check
      $error("posit_to_float: n must be 3..32 and es 0..3");
   end
   logic               s1_valid, s2_adv;
   logic               d_sign, d_zero, d_nar, r0, run;
   logic [n-2:0]       abs_v, rem, fr;
   logic [5:0]         m;
   logic [3:0]         e_v;
   logic signed [11:0] k, d_scale;
   logic [51:0]        d_frac;
   logic               s1_sign, s1_zero, s1_nar;
   logic signed [11:0] s1_scale;
   logic [51:0]        s1_frac;
   logic [FP_WIDTH-1:0] assembled;
   assign s2_adv     = ~out_valid_o | out_ready_i;
   assign in_ready_o = ~s1_valid | s2_adv;
   always_comb begin
      d_sign = operand_i[n-1];
      d_zero = operand_i == '0;
      d_nar  = operand_i == {1'b1, {(n-1){1'b0}}};
      abs_v  = d_sign ? -operand_i[n-2:0] : operand_i[n-2:0];
      r0     = abs_v[n-2];
      m      = '0;
      run    = 1'b1;
      for (int i = n - 2; i >= 0; i--) begin
         run = run & (abs_v[i] == r0);
         m   = m + {5'b0, run};
      end
      rem     = abs_v << (m + 6'd1);
      // padding rem with zeros below lets es exceed the bits left after the regime
      e_v     = 4'({rem, 3'b0} >> (n + 2 - es));
      fr      = rem << es;
      d_frac  = 52'({fr, 52'b0} >> (n - 1));
      k       = r0 ? 12'(m) - 12'sd1 : -12'(m);
      d_scale = (k <<< es) + 12'(e_v);
   end
   assign assembled = s1_zero ? '0 :
                      s1_nar  ? 64'h7FF8_0000_0000_0000 :
                      {s1_sign, 11'(s1_scale + 12'sd1023), s1_frac};
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid    <= 1'b0;
         out_valid_o <= 1'b0;
         result_o    <= '0;
      end else begin
         if (in_ready_o) s1_valid <= in_valid_i;
         if (in_valid_i && in_ready_o) begin
            s1_sign  <= d_sign;
            s1_zero  <= d_zero;
            s1_nar   <= d_nar;
            s1_scale <= d_scale;
            s1_frac  <= d_frac;
         end
         if (s2_adv) begin
            out_valid_o <= s1_valid;
            if (s1_valid) result_o <= assembled;
         end
      end
   end
endmodule
